// File: rtl/dp_cu_sequencer.sv
// dp_cu_sequencer: FIFO-buffered command issuer for DP_CU with go/done handshake, result hold and watchdog
module dp_cu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int W       = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [1:0]                   push_op,
    input  logic [W-1:0]                 push_a,
    input  logic [W-1:0]                 push_b,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         go,
    output logic [1:0]                   op,
    output logic [W-1:0]                 in1,
    output logic [W-1:0]                 in2,
    input  logic                         cu_done,
    input  logic [W-1:0]                 cu_out,
    output logic                         res_valid,
    output logic [1:0]                   res_op,
    output logic [W-1:0]                 res_data,
    input  logic                         res_ack,
    output logic                         err_timeout
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]     r_state;
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic [1:0]     r_mem_op [DEPTH];
    logic [W-1:0]   r_mem_a  [DEPTH];
    logic [W-1:0]   r_mem_b  [DEPTH];
    logic [WDW-1:0] r_wd;
    logic           r_go;
    logic [1:0]     r_op;
    logic [W-1:0]   r_in1;
    logic [W-1:0]   r_in2;
    logic           r_res_valid;
    logic [1:0]     r_res_op;
    logic [W-1:0]   r_res_data;
    logic           r_err;
    logic           w_push;
    logic           w_pop;
    logic           w_done;
    logic           w_tmo;

    assign full        = r_count == CW'(DEPTH);
    assign empty       = r_count == '0;
    assign count       = r_count;
    assign go          = r_go;
    assign op          = r_op;
    assign in1         = r_in1;
    assign in2         = r_in2;
    assign res_valid   = r_res_valid;
    assign res_op      = r_res_op;
    assign res_data    = r_res_data;
    assign err_timeout = r_err;

    assign w_push = push & ~full;
    assign w_pop  = (r_state == S_IDLE) & ~empty & (~r_res_valid | res_ack);
    assign w_done = (r_state == S_BUSY) & cu_done;
    assign w_tmo  = (r_state == S_BUSY) & ~cu_done & (r_wd == WDW'(TIMEOUT - 1));

    // Command storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr] <= push_op;
            r_mem_a[r_wr]  <= push_a;
            r_mem_b[r_wr]  <= push_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Issue FSM: launch from IDLE, hold go through BUSY until done or watchdog, one GAP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_go    <= 1'b0;
            r_op    <= '0;
            r_in1   <= '0;
            r_in2   <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_BUSY;
            r_go    <= 1'b1;
            r_op    <= r_mem_op[r_rd];
            r_in1   <= r_mem_a[r_rd];
            r_in2   <= r_mem_b[r_rd];
            r_wd    <= '0;
        end else if (r_state == S_BUSY) begin
            if (w_done | w_tmo) begin
                r_state <= S_GAP;
                r_go    <= 1'b0;
                r_err   <= r_err | w_tmo;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end else if (r_state == S_GAP) begin
            r_state <= S_IDLE;
        end
    end

    // Result register: capture on done, release on consumer ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_op    <= '0;
            r_res_data  <= '0;
        end else if (w_done) begin
            r_res_valid <= 1'b1;
            r_res_op    <= r_op;
            r_res_data  <= cu_out;
        end else if (res_ack) begin
            r_res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dp_cu_sequencer.sv
// tb_dp_cu_sequencer: randomized and directed checks of dp_cu_sequencer against a transaction-level model
module tb_dp_cu_sequencer;
    localparam int DEPTH   = 4;
    localparam int W       = 3;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst, push, cu_done, res_ack;
    logic [1:0]   push_op;
    logic [W-1:0] push_a, push_b, cu_out;
    logic         full, empty, go, res_valid, err_timeout;
    logic [2:0]   count;
    logic [1:0]   op, res_op;
    logic [W-1:0] in1, in2, res_data;

    always #5 clk = ~clk;

    dp_cu_sequencer #(.DEPTH(DEPTH), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .push(push), .push_op(push_op), .push_a(push_a), .push_b(push_b),
        .full(full), .empty(empty), .count(count), .go(go), .op(op), .in1(in1), .in2(in2),
        .cu_done(cu_done), .cu_out(cu_out), .res_valid(res_valid), .res_op(res_op),
        .res_data(res_data), .res_ack(res_ack), .err_timeout(err_timeout)
    );

    cmd_t         q[$];
    bit           m_go, m_gap, m_rv, m_err;
    logic [1:0]   m_op, m_rop;
    logic [W-1:0] m_in1, m_in2, m_rdata;
    int           m_gc;
    int           nchecks = 0;
    int           nerr = 0;
    int           fixed_lat = 0;
    int           cur_lat = 1;

    function automatic logic [W-1:0] alu(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit   was_full, launch;
        cmd_t c;
        if (rst) begin
            q.delete();
            m_go = 0; m_gap = 0; m_rv = 0; m_err = 0; m_gc = 0;
            m_op = 0; m_in1 = 0; m_in2 = 0; m_rop = 0; m_rdata = 0;
            return;
        end
        was_full = q.size() == DEPTH;
        launch   = !m_go && !m_gap && q.size() != 0 && (!m_rv || res_ack);
        if (m_rv && res_ack) m_rv = 0;
        if (m_go) begin
            if (cu_done) begin
                m_rv = 1; m_rdata = cu_out; m_rop = m_op; m_go = 0; m_gap = 1;
            end else if (m_gc + 1 == TIMEOUT) begin
                m_err = 1; m_go = 0; m_gap = 1;
            end else begin
                m_gc++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (launch) begin
            c = q.pop_front();
            m_op = c.op; m_in1 = c.a; m_in2 = c.b; m_go = 1; m_gc = 0;
        end
        if (push && !was_full) q.push_back({push_op, push_a, push_b});
    endtask

    task automatic compare();
        chk("go", go, m_go);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("res_valid", res_valid, m_rv);
        chk("err_timeout", err_timeout, m_err);
        if (m_go) begin
            chk("op", op, m_op);
            chk("in1", in1, m_in1);
            chk("in2", in2, m_in2);
        end
        if (m_rv) begin
            chk("res_op", res_op, m_rop);
            chk("res_data", res_data, m_rdata);
        end
    endtask

    task automatic drive_cu();
        if (m_go) begin
            if (m_gc == 0)
                cur_lat = fixed_lat != 0 ? fixed_lat :
                          ($urandom_range(0, 19) == 0 ? 1000 : int'($urandom_range(1, 7)));
            cu_done = (m_gc + 1 == cur_lat);
            cu_out  = cu_done ? alu(m_op, m_in1, m_in2) : W'($urandom);
        end else begin
            cu_done = $urandom_range(0, 3) == 0;
            cu_out  = W'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        drive_cu();
    endtask

    task automatic push_cmd(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        push = 1; push_op = o; push_a = a; push_b = b;
        step();
        push = 0;
    endtask

    task automatic ack_pulse();
        res_ack = 1;
        step();
        res_ack = 0;
    endtask

    task automatic wait_rv(input string name);
        int n = 0;
        while (!res_valid && n < 200) begin
            step();
            n++;
        end
        chk(name, res_valid, 1);
    endtask

    task automatic count_go_high(output int gc);
        int n = 0;
        while (!go && n < 20) begin
            step();
            n++;
        end
        gc = go ? 1 : 0;
        n = 0;
        while (go && n < 60) begin
            step();
            n++;
            if (go) gc++;
        end
    endtask

    initial begin
        int gc, peak;
        bit sawfull;
        rst = 1; push = 0; push_op = 0; push_a = 0; push_b = 0;
        cu_done = 0; cu_out = 0; res_ack = 0;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_go", go, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err", err_timeout, 0);
        rst = 0;

        fixed_lat = 5;
        push_cmd(2'd0, 3'd3, 3'd4);
        chk("add_count1", count, 1);
        step();
        chk("add_go", go, 1);
        chk("add_in1", in1, 3);
        chk("add_in2", in2, 4);
        gc = 1;
        for (int n = 0; n < 40 && go; n++) begin
            step();
            if (go) gc++;
        end
        chk("add_go_cycles", gc, 5);
        chk("add_valid", res_valid, 1);
        chk("add_data", res_data, 7);
        chk("add_op", res_op, 0);
        ack_pulse();

        fixed_lat = 3;
        push_cmd(2'd1, 3'd2, 3'd5);
        push_cmd(2'd3, 3'd6, 3'd3);
        wait_rv("sub_wait");
        chk("sub_data", res_data, 5);
        chk("sub_op", res_op, 1);
        ack_pulse();
        wait_rv("xor_wait");
        chk("xor_data", res_data, 5);
        chk("xor_op", res_op, 3);
        ack_pulse();

        fixed_lat = 2;
        peak = 0;
        sawfull = 0;
        for (int i = 0; i < 6; i++) begin
            push = 1; push_op = 0; push_a = 1; push_b = W'(i + 1);
            step();
            if (count > peak) peak = count;
            sawfull |= full;
        end
        push = 0;
        repeat (5) step();
        chk("full_peak", peak, 4);
        chk("full_seen", sawfull, 1);
        for (int i = 0; i < 5; i++) begin
            wait_rv("full_wait");
            chk("full_sum", res_data, 2 + i);
            ack_pulse();
        end
        repeat (6) step();
        chk("full_drained", empty, 1);
        chk("full_no_extra", res_valid, 0);

        push_cmd(2'd0, 3'd1, 3'd1);
        wait_rv("bp_first");
        push_cmd(2'd2, 3'd7, 3'd5);
        repeat (4) step();
        chk("bp_go_low", go, 0);
        chk("bp_count", count, 1);
        ack_pulse();
        chk("bp_go_high", go, 1);
        wait_rv("bp_second");
        chk("bp_data", res_data, 5);
        ack_pulse();

        fixed_lat = 1000;
        push_cmd(2'd0, 3'd2, 3'd2);
        push_cmd(2'd1, 3'd4, 3'd1);
        count_go_high(gc);
        chk("tmo_go_cycles", gc, TIMEOUT);
        chk("tmo_err", err_timeout, 1);
        chk("tmo_go", go, 0);
        chk("tmo_no_result", res_valid, 0);
        fixed_lat = 2;
        wait_rv("tmo_next");
        chk("tmo_next_data", res_data, 3);
        chk("tmo_sticky", err_timeout, 1);
        ack_pulse();

        fixed_lat = 1000;
        push_cmd(2'd0, 3'd1, 3'd2);
        push_cmd(2'd0, 3'd2, 3'd3);
        push_cmd(2'd0, 3'd3, 3'd4);
        step();
        chk("rmo_busy", go, 1);
        chk("rmo_queued", count, 2);
        rst = 1;
        step();
        rst = 0;
        chk("rmo_go", go, 0);
        chk("rmo_count", count, 0);
        chk("rmo_empty", empty, 1);
        chk("rmo_valid", res_valid, 0);
        chk("rmo_err", err_timeout, 0);
        fixed_lat = 0;
        repeat (8) step();
        chk("rmo_no_capture", res_valid, 0);

        for (int i = 0; i < 4000; i++) begin
            push    = $urandom_range(0, 1);
            push_op = 2'($urandom);
            push_a  = W'($urandom);
            push_b  = W'($urandom);
            res_ack = $urandom_range(0, 9) < 4;
            rst     = $urandom_range(0, 599) == 0;
            step();
        end
        rst = 0; push = 0; res_ack = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/dp_cu_sequencer.md
# dp_cu_sequencer

Command sequencer that sits directly upstream of the DP_CU datapath/control unit. It buffers up to DEPTH operation commands (op, in1, in2) in a FIFO. It issues them one at a time to DP_CU with the go/done handshake, and captures each 3-bit result into a held result register for a downstream consumer. A watchdog flags any DP_CU operation that never asserts done.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- W, 3: operand/result width; matches DP_CU in1/in2/out.
- TIMEOUT, 16: maximum go-high cycles allowed in BUSY before abort; ≥8.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  enqueue request; sampled on rising clk edge.
- push_op  in  2  command opcode: 00 add, 01 sub, 10 and, 11 xor.
- push_a  in  W  command operand A.
- push_b  in  W  command operand B.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- go  out  1  to DP_CU go.
- op  out  2  to DP_CU op; held stable while go=1.
- in1  out  W  to DP_CU in1; held stable while go=1.
- in2  out  W  to DP_CU in2; held stable while go=1.
- cu_done  in  1  from DP_CU done.
- cu_out  in  W  from DP_CU out; valid when cu_done=1.
- res_valid  out  1  result register holds an unconsumed result.
- res_op  out  2  opcode of the held result.
- res_data  out  W  held result.
- res_ack  in  1  consumer accepts the result; effective only when res_valid=1.
- err_timeout  out  1  sticky watchdog flag; cleared only by rst.

## Operation
- **Reset.** On a clk edge with rst=1:
  - state=IDLE; FIFO pointers and count cleared.
  - go=0, op/in1/in2=0.
  - res_valid=0, res_op=0, res_data=0, err_timeout=0.
  - Watchdog counter=0.
  - rst takes priority over every other input, including mid-BUSY; DP_CU sees go fall on that edge.
- **FIFO.**
  - A push is accepted iff push=1 and full=0 (registered values at the edge).
  - A push while full is dropped silently: count unchanged, contents unchanged. This holds even if a pop occurs on the same edge.
  - Pointers wrap modulo DEPTH.
  - Push and pop on the same edge leave count unchanged.
  - Ordering is strictly FIFO.
- **State machine:** IDLE → BUSY → GAP → IDLE.
  - IDLE: go=0. If empty=0 and (res_valid=0 or res_ack=1):
    - pop the head into op/in1/in2;
    - clear the watchdog;
    - go→1;
    - go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: go=1; op/in1/in2 frozen; watchdog increments each cycle.
    - If cu_done=1: res_data←cu_out, res_op←op, res_valid←1, go→0, go to GAP.
    - Else if watchdog == TIMEOUT-1: err_timeout←1, go→0, go to GAP. The result register is not written and the command is discarded.
    - cu_done takes priority over timeout on the same edge.
  - GAP: go=0 for exactly one cycle so DP_CU returns to its idle state (cs=0); then go to IDLE.
  - cu_done is ignored outside BUSY.
- **Result register.**
  - res_ack with res_valid=1 clears res_valid on that edge.
  - res_ack with res_valid=0 has no effect.
  - Capture never coincides with res_valid=1, because launch requires a free slot or an ack on the launch edge.
- **Arithmetic.** Done in DP_CU, modulo 2^W. The sequencer passes cu_out through unmodified.

## Timing
- Empty FIFO, IDLE, res_valid=0, push at edge E0:
  - count=1 after E0;
  - pop and go=1 after E1;
  - cu_done seen at edge E1+k;
  - res_valid=1 after E1+k.
- Issue-to-issue minimum: k+2 cycles (BUSY k cycles, GAP 1, then launch from IDLE).
- go never stays high across two commands; there is at least 1 cycle of go=0 between operations.
- full/empty/count are registered and update on the edge following push/pop.
- err_timeout rises on the edge ending the TIMEOUT-th go-high cycle.

## Test plan
- **Single add.** Push op=00, a=3, b=4, with a DP_CU model (done after 5 cycles) → go high for 5 cycles with in1=3, in2=4; then res_valid=1, res_data=7, res_op=00; GAP cycle has go=0.
- **Sub wrap and xor.** Push sub a=2, b=5, then xor a=6, b=3 → results in order: 5, then 5 (res_op 01, then 11); an ack between the results.
- **FIFO full.** With res_ack=0, push 6 commands back-to-back (add 1+1, 1+2, …) → first command issued and captured; count peaks at 4 and full=1; the 6th push is dropped. Acking each result then yields sums 2, 3, 4, 5, 6 only.
- **Backpressure.** With res_valid=1 and res_ack=0, and one command queued → go stays 0 and count stays 1. Asserting res_ack for one cycle → go=1 on the following cycle.
- **Timeout.** cu_done tied 0, TIMEOUT=16 → go high exactly 16 cycles, then err_timeout=1, go=0, res_valid stays 0. The next queued command is still issued; err_timeout stays 1 until rst.
- **Reset mid-op.** Assert rst while in BUSY with 2 commands queued → after the edge: go=0, count=0, empty=1, res_valid=0, err_timeout=0. No result is captured even if cu_done pulses afterwards.
